// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals shared between alu_arbiter and its environment.
// The slave modport is the arbiter's view; master is the view of whoever drives requests and hosts the ALU.
interface alu_arbiter_if #(
    parameter int DW   = 32,
    parameter int OPW  = 6,
    parameter int TAGW = 2
);
    logic            req0_valid;
    logic            req0_ready;
    logic [OPW-1:0]  req0_opcode;
    logic [DW-1:0]   req0_a;
    logic [DW-1:0]   req0_b;
    logic [TAGW-1:0] req0_tag;

    logic            req1_valid;
    logic            req1_ready;
    logic [OPW-1:0]  req1_opcode;
    logic [DW-1:0]   req1_a;
    logic [DW-1:0]   req1_b;
    logic [TAGW-1:0] req1_tag;

    logic [OPW-1:0]  alu_opcode;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic            alu_cin;
    logic            alu_vin;
    logic [DW-1:0]   alu_dout;
    logic            alu_cout;
    logic            alu_vout;
    logic            alu_mcp;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_src;
    logic [TAGW-1:0] rsp_tag;
    logic [DW-1:0]   rsp_data;
    logic            rsp_c;
    logic            rsp_v;

    logic [1:0]      flags0;
    logic [1:0]      flags1;

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_a, req1_b, req1_tag,
        output req1_ready,
        output alu_opcode, alu_a, alu_b, alu_cin, alu_vin,
        input  alu_dout, alu_cout, alu_vout, alu_mcp,
        output rsp_valid, rsp_src, rsp_tag, rsp_data, rsp_c, rsp_v,
        input  rsp_ready,
        output flags0, flags1
    );

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  alu_opcode, alu_a, alu_b, alu_cin, alu_vin,
        output alu_dout, alu_cout, alu_vout, alu_mcp,
        input  rsp_valid, rsp_src, rsp_tag, rsp_data, rsp_c, rsp_v,
        output rsp_ready,
        input  flags0, flags1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with per-requester C/V flags.
// Define ALU_ARB_B2B_EN to let a new op be accepted in the RESP cycle that hands off the previous result.
//
// state | meaning
// IDLE  | no op in flight; grant logic active
// EXEC  | operand registers drive the ALU; capture unless alu_mcp
// MCP   | extra cycle for a multi-cycle-path op; capture unconditionally
// RESP  | registered result presented until rsp_ready
module alu_arbiter #(
    parameter int DW   = 32,
    parameter int OPW  = 6,
    parameter int TAGW = 2
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MCP  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            src_q, src_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [TAGW-1:0] tag_q, tag_d;

    logic            rsp_src_q, rsp_src_d;
    logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_c_q, rsp_c_d;
    logic            rsp_v_q, rsp_v_d;
    logic [1:0]      flags0_q, flags0_d;
    logic [1:0]      flags1_q, flags1_d;

    logic            arb_active;
    logic            grant;
    logic            ready0;
    logic            ready1;
    logic            accept;
    logic            capture;

    always_comb begin
`ifdef ALU_ARB_B2B_EN
        arb_active = (state_q == S_IDLE) || ((state_q == S_RESP) && bus.rsp_ready);
`else
        arb_active = (state_q == S_IDLE);
`endif
        grant = ~last_grant_q;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = 1'b1;
        end
        ready0 = arb_active & ~grant;
        ready1 = arb_active & grant;
        accept = (ready0 & bus.req0_valid) | (ready1 & bus.req1_valid);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        src_d        = src_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        rsp_src_d    = rsp_src_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_data_d   = rsp_data_q;
        rsp_c_d      = rsp_c_q;
        rsp_v_d      = rsp_v_q;
        flags0_d     = flags0_q;
        flags1_d     = flags1_q;
        capture      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_EXEC: begin
                if (bus.alu_mcp) begin
                    state_d = S_MCP;
                end else begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_MCP: begin
                capture = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // accept is only ever true while arb_active, so it may override RESP->IDLE
        if (accept) begin
            state_d      = S_EXEC;
            src_d        = grant;
            last_grant_d = grant;
            op_d         = grant ? bus.req1_opcode : bus.req0_opcode;
            a_d          = grant ? bus.req1_a      : bus.req0_a;
            b_d          = grant ? bus.req1_b      : bus.req0_b;
            tag_d        = grant ? bus.req1_tag    : bus.req0_tag;
        end

        if (capture) begin
            rsp_src_d  = src_q;
            rsp_tag_d  = tag_q;
            rsp_data_d = bus.alu_dout;
            rsp_c_d    = bus.alu_cout;
            rsp_v_d    = bus.alu_vout;
            if (src_q) begin
                flags1_d = {bus.alu_cout, bus.alu_vout};
            end else begin
                flags0_d = {bus.alu_cout, bus.alu_vout};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            src_q        <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            rsp_src_q    <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_data_q   <= '0;
            rsp_c_q      <= 1'b0;
            rsp_v_q      <= 1'b0;
            flags0_q     <= 2'b00;
            flags1_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            src_q        <= src_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_q        <= tag_d;
            rsp_src_q    <= rsp_src_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_data_q   <= rsp_data_d;
            rsp_c_q      <= rsp_c_d;
            rsp_v_q      <= rsp_v_d;
            flags0_q     <= flags0_d;
            flags1_q     <= flags1_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    assign bus.alu_opcode = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_cin    = src_q ? flags1_q[1] : flags0_q[1];
    assign bus.alu_vin    = src_q ? flags1_q[0] : flags0_q[0];

    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_src    = rsp_src_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_c      = rsp_c_q;
    assign bus.rsp_v      = rsp_v_q;

    assign bus.flags0     = flags0_q;
    assign bus.flags1     = flags1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small ALU model, requester drivers and a scoreboard monitor.
module tb_alu_arbiter;

    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_XOR = 6'h03;
    localparam logic [5:0] OP_MUL = 6'h04;
    localparam logic [5:0] OP_LSR = 6'h05;

`ifdef ALU_ARB_B2B_EN
    localparam int RELEASE_GAP = 0;
`else
    localparam int RELEASE_GAP = 1;
`endif

    typedef struct {
        logic        src;
        logic [1:0]  tag;
        logic [31:0] data;
        logic        c;
        logic        v;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic force_mcp = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t exp_q[$];
    int   acc_q[$];

    alu_arbiter_if #(.DW(32), .OPW(6), .TAGW(2)) bus ();

    alu_arbiter #(.DW(32), .OPW(6), .TAGW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: carry/overflow pass through for XOR, MUL and LSR by 0.
    logic [32:0] sum33;
    int          sh;
    always_comb begin
        sum33        = 33'd0;
        sh           = 0;
        bus.alu_dout = 32'd0;
        bus.alu_cout = bus.alu_cin;
        bus.alu_vout = bus.alu_vin;
        bus.alu_mcp  = 1'b0;
        case (bus.alu_opcode)
            OP_ADD: begin
                sum33        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_dout = sum33[31:0];
                bus.alu_cout = sum33[32];
                bus.alu_vout = (bus.alu_a[31] == bus.alu_b[31]) && (sum33[31] != bus.alu_a[31]);
            end
            OP_SUB: begin
                bus.alu_dout = bus.alu_a - bus.alu_b;
                bus.alu_cout = (bus.alu_a < bus.alu_b);
                bus.alu_vout = (bus.alu_a[31] != bus.alu_b[31]) && (bus.alu_dout[31] != bus.alu_a[31]);
            end
            OP_XOR: bus.alu_dout = bus.alu_a ^ bus.alu_b;
            OP_MUL: begin
                bus.alu_dout = bus.alu_a * bus.alu_b;
                bus.alu_mcp  = force_mcp;
            end
            OP_LSR: begin
                sh           = int'(bus.alu_b[4:0]);
                bus.alu_dout = bus.alu_a >> sh;
                if (sh != 0) bus.alu_cout = bus.alu_a[sh-1];
            end
            default: bus.alu_dout = 32'd0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic src, input logic [1:0] tag, input logic [31:0] data,
                            input logic c, input logic v, input int lat);
        exp_t e;
        e.src = src; e.tag = tag; e.data = data; e.c = c; e.v = v; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: compares the head expectation on every cycle rsp_valid is high.
    initial begin
        exp_t e;
        int   a0;
        bit   in_resp;
        in_resp = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                acc_q.delete();
                in_resp = 0;
            end else begin
                if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
                    acc_q.push_back(cyc);
                if (bus.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                    end else begin
                        e = exp_q[0];
                        if (!in_resp) begin
                            if (acc_q.size() == 0) begin
                                chk("rsp_without_accept", 32'd1, 32'd0);
                            end else begin
                                a0 = acc_q.pop_front();
                                chk("latency", 32'(cyc - a0), 32'(e.lat));
                            end
                        end
                        in_resp = 1;
                        chk("rsp_src",  32'(bus.rsp_src), 32'(e.src));
                        chk("rsp_tag",  32'(bus.rsp_tag), 32'(e.tag));
                        chk("rsp_data", bus.rsp_data,     e.data);
                        chk("rsp_cv",   32'({bus.rsp_c, bus.rsp_v}), 32'({e.c, e.v}));
                        if (!bus.rsp_ready) begin
                            chk("ready_during_stall", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
                        end else begin
                            void'(exp_q.pop_front());
                            in_resp = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic drive0(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] tag, output int acc);
        int n;
        n = 0;
        acc = -1;
        bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag;
        bus.req0_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req0_ready && n < 100);
        if (bus.req0_ready) acc = cyc;
        else chk("req0_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
    endtask

    task automatic drive1(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] tag, output int acc);
        int n;
        n = 0;
        acc = -1;
        bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag;
        bus.req1_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req1_ready && n < 100);
        if (bus.req1_ready) acc = cyc;
        else chk("req1_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int acc0, acc1, h, n;
        bit saw;
        bus.req0_valid = 1'b0; bus.req0_opcode = '0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_tag = '0;
        bus.req1_valid = 1'b0; bus.req1_opcode = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_tag = '0;
        bus.rsp_ready = 1'b1;

        do_reset();
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data",  bus.rsp_data, 32'd0);
        chk("reset_alu_a",     bus.alu_a, 32'd0);
        chk("reset_alu_op",    32'(bus.alu_opcode), 32'd0);
        chk("reset_flags",     32'({bus.flags0, bus.flags1}), 32'd0);
        @(posedge clk);
        #1;

        // overflow on signed add; V lands in flags0 only
        push_exp(1'b0, 2'd2, 32'h8000_0000, 1'b0, 1'b1, 2);
        drive0(OP_ADD, 32'h7FFF_FFFF, 32'd1, 2'd2, acc0);
        drain();
        chk("t1_flags0", 32'(bus.flags0), 32'd1);
        chk("t1_flags1", 32'(bus.flags1), 32'd0);

        // both requesters saturated: strict alternation starting with requester 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 2'd1, 32'd2,    1'b0, 1'b0, 2);
            push_exp(1'b1, 2'd3, 32'h0F,   1'b0, 1'b0, 2);
        end
        fork
            begin
                int a;
                for (int i = 0; i < 4; i++) drive0(OP_SUB, 32'd5, 32'd3, 2'd1, a);
            end
            begin
                int a;
                for (int i = 0; i < 4; i++) drive1(OP_XOR, 32'hF0, 32'hFF, 2'd3, a);
            end
        join
        drain();
        chk("t2_flags", 32'({bus.flags0, bus.flags1}), 32'd0);

        // multi-cycle op: operands must hold through EXEC and MCP
        force_mcp = 1'b1;
        push_exp(1'b0, 2'd1, 32'd21, 1'b0, 1'b0, 3);
        drive0(OP_MUL, 32'd3, 32'd7, 2'd1, acc0);
        @(negedge clk);
        chk("t3_exec_alu_ab", {bus.alu_a[15:0], bus.alu_b[15:0]}, {16'd3, 16'd7});
        @(negedge clk);
        chk("t3_mcp_alu_ab",  {bus.alu_a[15:0], bus.alu_b[15:0]}, {16'd3, 16'd7});
        drain();
        force_mcp = 1'b0;

        // backpressure: req0 waits behind a stalled req1 response
        bus.rsp_ready = 1'b0;
        push_exp(1'b1, 2'd0, 32'h05, 1'b0, 1'b0, 2);
        drive1(OP_XOR, 32'h0F, 32'h0A, 2'd0, acc1);
        push_exp(1'b0, 2'd3, 32'd0, 1'b1, 1'b0, 2);
        h = -1;
        fork
            drive0(OP_ADD, 32'hFFFF_FFFF, 32'd1, 2'd3, acc0);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.rsp_valid && n < 50);
                chk("t4_rsp_seen", 32'(bus.rsp_valid), 32'd1);
                repeat (5) @(negedge clk);
                @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
                @(negedge clk);
                h = cyc;
            end
        join
        chk("t4_accept_after_release", 32'(acc0 - h), 32'(RELEASE_GAP));
        drain();
        chk("t4_flags0", 32'(bus.flags0), 32'd2);
        chk("t4_flags1", 32'(bus.flags1), 32'd0);

        // reset in EXEC drops the op silently and clears the flags
        drive1(OP_LSR, 32'h8000_0000, 32'd4, 2'd2, acc1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        saw = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) saw = 1;
        end
        chk("t5_no_rsp_after_reset", 32'(saw), 32'd0);
        chk("t5_flags_cleared", 32'({bus.flags0, bus.flags1}), 32'd0);
        chk("t5_rsp_data_cleared", bus.rsp_data, 32'd0);
        @(posedge clk);
        #1;

        // requester 0 wins first; LSR by 0 returns requester 1's own carry
        push_exp(1'b0, 2'd0, 32'd0,         1'b1, 1'b0, 2);
        push_exp(1'b1, 2'd1, 32'h8000_0000, 1'b0, 1'b0, 2);
        fork
            drive0(OP_ADD, 32'hFFFF_FFFF, 32'd1, 2'd0, acc0);
            drive1(OP_LSR, 32'h8000_0000, 32'd0, 2'd1, acc1);
        join
        drain();
        chk("t6_req0_first", 32'(acc1 > acc0), 32'd1);
        chk("t6_flags0", 32'(bus.flags0), 32'd2);
        chk("t6_flags1", 32'(bus.flags1), 32'd0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (adder/logic/multiplier/barrel shifter) between two requesters, for example the main execute stage and a secondary unit.
- Arbitrates round-robin, registers operands, and drives the ALU from those registers.
- Grants the extra cycle for multi-cycle-path ops flagged by the ALU's mcp_out.
- Returns a registered, tagged result and keeps a separate C/V flag set per requester.

Parameters:
- DW, 32, operand/result width (must match ALU, 32).
- OPW, 6, opcode width (cpu_2432.vh encodings).
- TAGW, 2, requester-supplied tag width echoed on the response.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  arbiter accepts requester 0 op this cycle
- req0_opcode  in  OPW  op for requester 0
- req0_a, req0_b  in  DW  operands (b supplies shift distance/bit index in [4:0])
- req0_tag  in  TAGW  tag
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b, req1_tag  same for requester 1
- alu_opcode  out  OPW  to ALU opcode
- alu_a, alu_b  out  DW  to ALU din_a/din_b
- alu_cin, alu_vin  out  1  to ALU cin/vin, from the owning requester's flags
- alu_dout  in  DW  ALU result
- alu_cout, alu_vout, alu_mcp  in  1  ALU carry, overflow, multi-cycle flag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_src  out  1  requester index of result
- rsp_tag  out  TAGW  echoed tag
- rsp_data  out  DW  result
- rsp_c, rsp_v  out  1  flags after op
- flags0, flags1  out  2  {C,V} per requester

Behaviour:
- States: IDLE, EXEC, MCP, RESP.
- Reset (any state, including mid-op): state=IDLE; rsp_valid=0; rsp_src/tag/data/c/v=0; flags0=flags1=0; last_grant=1, so requester 0 wins first; op/operand registers=0. Any in-flight op is dropped with no response.
- alu_* outputs always reflect the operand registers; they are 0 after reset.
- Grant, combinational, only in IDLE:
  - Only one valid: grant it.
  - Both valid: grant !last_grant.
  - reqN_ready = (state==IDLE) & grant==N. The other ready stays 0.
  - Ready does not depend on the requester's own valid beyond the grant choice.
- Accept on reqN_valid & reqN_ready:
  - Capture opcode, a, b, tag, src=N.
  - Set last_grant=N.
  - Go to EXEC.
- EXEC:
  - alu_cin/alu_vin = flags[src].
  - If alu_mcp=0: capture alu_dout/cout/vout into rsp_data/rsp_c/rsp_v, write {cout,vout} into flags[src], go to RESP.
  - If alu_mcp=1: go to MCP, holding inputs stable.
- MCP: unconditionally capture as in EXEC, go to RESP. Exactly one extra cycle.
- RESP:
  - rsp_valid=1, all rsp_* stable while rsp_ready=0 (arbitrary backpressure).
  - On rsp_ready, go to IDLE and deassert rsp_valid next cycle.
- Latency, accept edge T:
  - Non-mcp: rsp_valid high at T+2 (1 EXEC cycle).
  - mcp: rsp_valid high at T+3.
  - Throughput without the option: one op per 3 cycles minimum.
- Flags:
  - Only the src requester's flags change, and only at the capture edge.
  - The other requester's flags are never touched.
  - Ops for which the ALU passes cin/vin through leave flags unchanged by construction.
- Invalid/unknown opcodes are passed through unchecked; the ALU default applies.
- A request with valid dropped before ready is never latched. Requesters must hold valid and payload until ready.

Optional Feature:
- ALU_ARB_B2B_EN defined:
  - In RESP with rsp_ready=1, the grant logic is also active and reqN_ready may assert in the same cycle.
  - An accept then goes directly RESP→EXEC, giving throughput of one op per 2 cycles.
  - flags[src] for the new op are already updated, because the previous capture edge is complete.
  - Round-robin still uses last_grant.
- Not defined: ready only in IDLE, exactly as above.

Test Plan:
- Reset, then req0 `ADD a=0x7FFFFFFF b=1 tag=2 → rsp_valid 2 cycles after accept; data=0x80000000, v=1, src=0, tag=2; flags0 V=1, flags1=0.
- Both valid continuously (req0 `SUB 5-3, req1 `XOR 0xF0^0xFF) → grants alternate 0,1,0,1; results 2 and 0x0F with correct src/tag; no starvation over 8 ops.
- Force alu_mcp=1 on `MUL a=3 b=7 → rsp_valid 3 cycles after accept; data=21; alu_a/b stable through EXEC and MCP.
- Hold rsp_ready=0 for 5 cycles → rsp_* stable, both readies stay 0. Release → next op accepted in the IDLE cycle after (in the same cycle with ALU_ARB_B2B_EN).
- Assert reset during EXEC of req1 `LSR 0x80000000 by 4 → no rsp_valid, flags cleared; next req0 is granted first.
- Per-requester flags: req0 `ADD 0xFFFFFFFF+1 sets flags0 C=1. Then req1 `LSR 0x80000000 by 0 passes cin from flags1 (0), so rsp_c=0 and flags0 is unchanged.
